// File: rtl/alu_pkg.sv
// Shared encodings for the ALU execute unit: operation codes, alu_op classes,
// FSM states, funct7 values and the iterative multiply/divide operation set.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLTU = 4'b1000,
        ALU_NOR  = 4'b1100,
        ALU_SRA  = 4'b1101
    } alu_code_t;

    localparam logic [1:0] CLS_LDST   = 2'b00;
    localparam logic [1:0] CLS_BRANCH = 2'b01;
    localparam logic [1:0] CLS_RTYPE  = 2'b10;
    localparam logic [1:0] CLS_ITYPE  = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef enum logic [2:0] {
        MD_MUL   = 3'd0,
        MD_MULHU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_REM   = 3'd4,
        MD_REMU  = 3'd5
    } md_op_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide: one shift-add or restoring-divide step per cycle,
// WIDTH cycles per operation. Only instantiated when ALU_MULDIV_EN is defined.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  md_op_t           i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    md_op_t           r_op;
    logic             r_is_mul;
    logic [WIDTH-1:0] r_hi, r_lo, r_b, r_a;
    logic             r_neg_q, r_neg_r, r_div0;

    logic             w_signed, w_mul, w_a_neg, w_b_neg;
    logic [WIDTH:0]   w_sum, w_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub, w_hi_n, w_lo_n, w_q, w_r;

    assign w_signed = (i_op == MD_DIV) || (i_op == MD_REM);
    assign w_mul    = (i_op == MD_MUL) || (i_op == MD_MULHU);
    assign w_a_neg  = w_signed && i_a[WIDTH-1];
    assign w_b_neg  = w_signed && i_b[WIDTH-1];

    // Multiply: {hi,lo} accumulates with lo holding the remaining multiplier bits.
    assign w_sum = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : '0)};
    // Divide: remainder in hi, dividend shifts out of lo as quotient bits shift in.
    assign w_sh  = {r_hi, r_lo[WIDTH-1]};
    assign w_ge  = (w_sh >= {1'b0, r_b});
    assign w_sub = w_sh[WIDTH-1:0] - r_b;

    always_comb begin
        w_hi_n = r_hi;
        w_lo_n = r_lo;
        if (r_is_mul) begin
            w_hi_n = w_sum[WIDTH:1];
            w_lo_n = {w_sum[0], r_lo[WIDTH-1:1]};
        end else begin
            w_hi_n = w_ge ? w_sub : w_sh[WIDTH-1:0];
            w_lo_n = {r_lo[WIDTH-2:0], w_ge};
        end
    end

    assign w_q = r_div0 ? '1  : (r_neg_q ? -w_lo_n : w_lo_n);
    assign w_r = r_div0 ? r_a : (r_neg_r ? -w_hi_n : w_hi_n);

    always_comb begin
        o_result = '0;
        case (r_op)
            MD_MUL:           o_result = w_lo_n;
            MD_MULHU:         o_result = w_hi_n;
            MD_DIV, MD_DIVU:  o_result = w_q;
            MD_REM, MD_REMU:  o_result = w_r;
            default:          o_result = '0;
        endcase
    end

    assign o_done = r_busy && (r_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_op     <= MD_MUL;
            r_is_mul <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_a      <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= CNT_W'(WIDTH - 1);
            r_op     <= i_op;
            r_is_mul <= w_mul;
            r_hi     <= '0;
            r_lo     <= w_mul ? i_b : (w_a_neg ? -i_a : i_a);
            r_b      <= w_mul ? i_a : (w_b_neg ? -i_b : i_b);
            r_a      <= i_a;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div0   <= (i_b == '0);
        end else if (r_busy) begin
            r_hi  <= w_hi_n;
            r_lo  <= w_lo_n;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) r_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute unit with valid/ready handshake on both sides. Define
// ALU_MULDIV_EN to add the iterative multiply/divide operations.
//
// state | meaning
// IDLE  | waiting for a request (in_ready once out of reset)
// EXEC  | iterative multiply/divide running, requests ignored
// DONE  | result held until out_ready; may accept the next request same cycle
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [6:0]       funct7,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic             busy
);
    state_t           r_state, w_state_nxt;
    logic             r_init;
    logic [WIDTH-1:0] r_result;
    logic             r_zero, r_illegal;

    alu_code_t        w_code;
    logic             w_illegal, w_iter, w_accept;
    logic             w_rtype, w_f7_base, w_f7_alt;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_md_done;
    logic [WIDTH-1:0] w_md_result;

    assign w_rtype   = (alu_op == CLS_RTYPE);
    assign w_f7_base = (funct7 == F7_BASE);
    assign w_f7_alt  = (funct7 == F7_ALT);
    assign w_shamt   = op_b[SHAMT_W-1:0];

`ifdef ALU_MULDIV_EN
    md_op_t w_mdop;
    logic   w_start;

    assign w_start = w_accept && w_iter;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_start),
        .i_op     (w_mdop),
        .i_a      (op_a),
        .i_b      (op_b),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );
`else
    assign w_md_done   = 1'b0;
    assign w_md_result = '0;
`endif

    always_comb begin
        w_code    = ALU_ADD;
        w_illegal = 1'b0;
        w_iter    = 1'b0;
`ifdef ALU_MULDIV_EN
        w_mdop    = MD_MUL;
`endif
        if (alu_op == CLS_BRANCH) begin
            w_code = ALU_SUB;
        end else if (alu_op == CLS_LDST) begin
            w_code = ALU_ADD;
        end else if (w_rtype && funct7 == F7_MULDIV) begin
`ifdef ALU_MULDIV_EN
            w_iter = 1'b1;
            case (funct3)
                3'b000:  w_mdop = MD_MUL;
                3'b011:  w_mdop = MD_MULHU;
                3'b100:  w_mdop = MD_DIV;
                3'b101:  w_mdop = MD_DIVU;
                3'b110:  w_mdop = MD_REM;
                3'b111:  w_mdop = MD_REMU;
                default: begin w_iter = 1'b0; w_illegal = 1'b1; end
            endcase
`else
            w_illegal = 1'b1;
`endif
        end else begin
            // I-type ignores funct7 except on the shifts, where it selects/validates the shift kind.
            case (funct3)
                3'b000: begin
                    w_code    = (w_rtype && w_f7_alt) ? ALU_SUB : ALU_ADD;
                    w_illegal = w_rtype && !(w_f7_base || w_f7_alt);
                end
                3'b001: begin w_code = ALU_SLL;  w_illegal = !w_f7_base; end
                3'b010: begin w_code = ALU_SLT;  w_illegal = w_rtype && !w_f7_base; end
                3'b011: begin w_code = ALU_SLTU; w_illegal = w_rtype && !w_f7_base; end
                3'b100: begin w_code = ALU_XOR;  w_illegal = w_rtype && !w_f7_base; end
                3'b101: begin
                    w_code    = w_f7_alt ? ALU_SRA : ALU_SRL;
                    w_illegal = !(w_f7_base || w_f7_alt);
                end
                3'b110: begin w_code = ALU_OR;   w_illegal = w_rtype && !w_f7_base; end
                default: begin w_code = ALU_AND; w_illegal = w_rtype && !w_f7_base; end
            endcase
        end
    end

    always_comb begin
        w_alu_res = '0;
        case (w_code)
            ALU_AND:  w_alu_res = op_a & op_b;
            ALU_OR:   w_alu_res = op_a | op_b;
            ALU_ADD:  w_alu_res = op_a + op_b;
            ALU_SUB:  w_alu_res = op_a - op_b;
            ALU_XOR:  w_alu_res = op_a ^ op_b;
            ALU_NOR:  w_alu_res = ~(op_a | op_b);
            ALU_SLL:  w_alu_res = op_a << w_shamt;
            ALU_SRL:  w_alu_res = op_a >> w_shamt;
            ALU_SRA:  w_alu_res = $signed(op_a) >>> w_shamt;
            ALU_SLT:  w_alu_res[0] = $signed(op_a) < $signed(op_b);
            ALU_SLTU: w_alu_res[0] = op_a < op_b;
            default:  w_alu_res = '0;
        endcase
    end

    assign in_ready  = ((r_state == ST_IDLE) && r_init) || ((r_state == ST_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_EXEC);
    assign result    = r_result;
    assign zero      = r_zero;
    assign illegal   = r_illegal;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = w_iter ? ST_EXEC : ST_DONE;
            ST_EXEC: if (w_md_done) w_state_nxt = ST_DONE;
            ST_DONE: begin
                if (w_accept)       w_state_nxt = w_iter ? ST_EXEC : ST_DONE;
                else if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_init  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_init  <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_accept && !w_iter) begin
            r_result  <= w_illegal ? '0 : w_alu_res;
            r_zero    <= w_illegal || (w_alu_res == '0);
            r_illegal <= w_illegal;
        end else if ((r_state == ST_EXEC) && w_md_done) begin
            r_result  <= w_md_result;
            r_zero    <= (w_md_result == '0);
            r_illegal <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (WIDTH=32); muldiv scenarios
// are included when ALU_MULDIV_EN is defined.
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [1:0]  alu_op = 2'b00;
    logic [6:0]  funct7 = 7'h00;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        in_ready, out_valid, zero, illegal, busy;
    logic [31:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct7    (funct7),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal),
        .busy      (busy)
    );

    typedef struct {
        logic [1:0]  op;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        ill;
    } vec_t;

    task automatic drive(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b);
        alu_op = op; funct7 = f7; funct3 = f3; op_a = a; op_b = b; in_valid = 1'b1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        n_cmp++;
        if ({out_valid, zero, illegal, busy, in_ready, result} !== 37'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ov=%b z=%b il=%b bz=%b ir=%b res=%h, want all 0",
                     out_valid, zero, illegal, busy, in_ready, result);
        end
        tick; tick;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL ready_before_edge: got %b want 0", in_ready);
        end
        tick;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL ready_after_release: got %b want 1", in_ready);
        end
    endtask

    task automatic test_sub;
        out_ready = 1'b1;
        drive(2'b10, 7'h20, 3'b000, 32'd5, 32'd7);
        tick;
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, zero, illegal, result} !== {3'b100, 32'hFFFF_FFFE}) begin
            n_bad++;
            $display("FAIL sub_5_7: got ov=%b z=%b il=%b res=%h want ov=1 z=0 il=0 res=fffffffe",
                     out_valid, zero, illegal, result);
        end
        tick;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL sub_drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_vectors;
        vec_t v[14];
        v = '{
            '{2'b11, 7'h20, 3'b101, 32'h8000_0000, 32'd4,   32'hF800_0000, 1'b0},
            '{2'b11, 7'h00, 3'b101, 32'h8000_0000, 32'd4,   32'h0800_0000, 1'b0},
            '{2'b00, 7'h55, 3'b111, 32'd10,        32'd20,  32'd30,        1'b0},
            '{2'b01, 7'h7F, 3'b100, 32'd3,         32'd3,   32'd0,         1'b0},
            '{2'b00, 7'h00, 3'b000, 32'hFFFF_FFFF, 32'd2,   32'd1,         1'b0},
            '{2'b10, 7'h00, 3'b001, 32'd1,         32'd33,  32'd2,         1'b0},
            '{2'b10, 7'h00, 3'b010, 32'hFFFF_FFFF, 32'd1,   32'd1,         1'b0},
            '{2'b10, 7'h00, 3'b011, 32'hFFFF_FFFF, 32'd1,   32'd0,         1'b0},
            '{2'b10, 7'h00, 3'b100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0},
            '{2'b10, 7'h00, 3'b110, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0},
            '{2'b10, 7'h00, 3'b111, 32'h0000_00F0, 32'h0000_003C, 32'h0000_0030, 1'b0},
            '{2'b11, 7'h20, 3'b000, 32'd5,         32'd7,   32'd12,        1'b0},
            '{2'b11, 7'h7F, 3'b111, 32'h0000_00FF, 32'h0000_000F, 32'h0000_000F, 1'b0},
            '{2'b10, 7'h10, 3'b000, 32'd9,         32'd9,   32'd0,         1'b1}
        };
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            drive(v[i].op, v[i].f7, v[i].f3, v[i].a, v[i].b);
            tick;
            in_valid = 1'b0;
            n_cmp++;
            if ({out_valid, illegal, zero, result} !== {1'b1, v[i].ill, (v[i].exp == 32'd0), v[i].exp}) begin
                n_bad++;
                $display("FAIL vector_%0d: got ov=%b il=%b z=%b res=%h want ov=1 il=%b z=%b res=%h",
                         i, out_valid, illegal, zero, result, v[i].ill, (v[i].exp == 32'd0), v[i].exp);
            end
            tick;
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b0;
        drive(2'b00, 7'h00, 3'b000, 32'd3, 32'd4);
        tick;
        drive(2'b10, 7'h00, 3'b010, 32'hFFFF_FFFF, 32'd1);
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if ({out_valid, in_ready, result} !== {2'b10, 32'd7}) begin
                n_bad++;
                $display("FAIL hold_cycle_%0d: got ov=%b ir=%b res=%h want ov=1 ir=0 res=00000007",
                         c, out_valid, in_ready, result);
            end
            tick;
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL b2b_ready: got %b want 1", in_ready);
        end
        tick;
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, result} !== {1'b1, 32'd1}) begin
            n_bad++;
            $display("FAIL b2b_slt: got ov=%b res=%h want ov=1 res=00000001", out_valid, result);
        end
        tick;
    endtask

`ifdef ALU_MULDIV_EN
    task automatic run_iter(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp, input int id);
        int bad_exec;
        out_ready = 1'b1;
        drive(2'b10, 7'h01, f3, a, b);
        tick;
        drive(2'b00, 7'h00, 3'b000, 32'd1, 32'd1);
        bad_exec = 0;
        for (int c = 1; c <= 32; c++) begin
            if (c == 32) in_valid = 1'b0;
            if (!(busy === 1'b1 && out_valid === 1'b0 && in_ready === 1'b0)) bad_exec++;
            tick;
        end
        n_cmp++;
        if (bad_exec !== 0) begin
            n_bad++; $display("FAIL iter_%0d_exec: got %0d bad EXEC cycles want 0", id, bad_exec);
        end
        n_cmp++;
        if ({out_valid, busy, result} !== {2'b10, exp}) begin
            n_bad++;
            $display("FAIL iter_%0d_result: got ov=%b bz=%b res=%h want ov=1 bz=0 res=%h",
                     id, out_valid, busy, result, exp);
        end
        tick;
    endtask

    task automatic test_muldiv;
        run_iter(3'b101, 32'd100,        32'd0,         32'hFFFF_FFFF, 0);
        run_iter(3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);
        run_iter(3'b000, 32'd7,          32'd6,         32'd42,        2);
        run_iter(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 3);
        run_iter(3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 4);
        run_iter(3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 5);
        run_iter(3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 6);
        run_iter(3'b111, 32'd100,        32'd7,         32'd2,         7);
        run_iter(3'b100, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 8);
        run_iter(3'b110, 32'd55,         32'd0,         32'd55,        9);
        drive(2'b10, 7'h01, 3'b001, 32'd3, 32'd5);
        tick;
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, illegal, result} !== {2'b11, 32'd0}) begin
            n_bad++;
            $display("FAIL muldiv_f3_001: got ov=%b il=%b res=%h want ov=1 il=1 res=0",
                     out_valid, illegal, result);
        end
        tick;
    endtask
`else
    task automatic test_no_muldiv;
        out_ready = 1'b1;
        drive(2'b10, 7'h01, 3'b000, 32'd3, 32'd5);
        tick;
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, illegal, busy, result} !== {3'b110, 32'd0}) begin
            n_bad++;
            $display("FAIL no_muldiv: got ov=%b il=%b bz=%b res=%h want ov=1 il=1 bz=0 res=0",
                     out_valid, illegal, busy, result);
        end
        tick;
    endtask
`endif

    task automatic test_reset_abort(input logic iter);
        int seen_valid;
        if (iter) begin
            out_ready = 1'b1;
            drive(2'b10, 7'h01, 3'b000, 32'd7, 32'd6);
            tick;
            in_valid = 1'b0;
            repeat (9) tick;
        end else begin
            out_ready = 1'b0;
            drive(2'b00, 7'h00, 3'b000, 32'd3, 32'd4);
            tick;
            in_valid = 1'b0;
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, zero, illegal, busy, in_ready, result} !== 37'd0) begin
            n_bad++;
            $display("FAIL abort_%0d_outputs: got ov=%b z=%b il=%b bz=%b ir=%b res=%h want all 0",
                     iter, out_valid, zero, illegal, busy, in_ready, result);
        end
        out_ready = 1'b1;
        tick; tick;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL abort_%0d_ready_early: got %b want 0", iter, in_ready);
        end
        tick;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL abort_%0d_ready: got %b want 1", iter, in_ready);
        end
        seen_valid = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid !== 1'b0) seen_valid++;
            tick;
        end
        n_cmp++;
        if (seen_valid !== 0) begin
            n_bad++; $display("FAIL abort_%0d_no_valid: got %0d out_valid cycles want 0", iter, seen_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sub();
        test_vectors();
        test_back_to_back();
`ifdef ALU_MULDIV_EN
        test_muldiv();
        test_reset_abort(1'b1);
`else
        test_no_muldiv();
`endif
        test_reset_abort(1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal: 8, 16, 32, 64).
REQ-002 SHALL have parameter SHAMT_W, default $clog2(WIDTH), number of shift-amount bits taken from op_b.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  request present; in_ready  output  1  unit can accept a request.
REQ-006 alu_op  input  2  class: 00 = load/store add, 01 = branch subtract, 10 = R-type, 11 = I-type.
REQ-007 funct7  input  7; funct3  input  3  instruction function fields.
REQ-008 op_a, op_b  input  WIDTH  operands; op_b carries the immediate for I-type.
REQ-009 out_valid  output  1  result present; out_ready  input  1  consumer accepts the result.
REQ-010 result  output  WIDTH; zero  output  1 (result == 0); illegal  output  1 (undecodable request); busy  output  1 (iterative operation in progress).

Function
REQ-011 Decode codes SHALL be: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, XOR 0011, SLL 0100, SRL 0101, SRA 1101, SLTU 1000.
REQ-012 alu_op 00 SHALL decode to ADD and alu_op 01 to SUB, with funct fields ignored.
REQ-013 R-type funct3 mapping: 000 ADD (funct7 0x00) or SUB (funct7 0x20); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL (0x00) or SRA (0x20); 110 OR; 111 AND.
REQ-014 I-type SHALL use the same mapping with funct7 ignored, except for SLL, SRL and SRA; funct3 000 is always ADD.
REQ-015 Any other funct7 value on R-type SHALL set illegal=1 and result=0, with normal handshake timing.
REQ-016 Shift amount SHALL be op_b[SHAMT_W-1:0]; SLT SHALL compare signed, SLTU unsigned; result SHALL be 1 or 0, zero-extended.
REQ-017 ADD and SUB SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-018 FSM states: IDLE, EXEC, DONE.
  - IDLE: in_ready=1. A transfer occurs when in_valid && in_ready.
  - Single-cycle ops go IDLE->DONE, so out_valid is asserted on the cycle after acceptance.
  - Iterative ops go IDLE->EXEC->DONE.
REQ-019 DONE SHALL hold result, zero, illegal and out_valid stable until out_ready=1.
REQ-020 In DONE, in_ready SHALL equal out_ready. A simultaneous result drain and new accept SHALL move directly to the next op's state, with no bubble cycle.
REQ-021 in_valid seen while in EXEC SHALL be ignored (in_ready=0); busy=1 only in EXEC.
REQ-022 out_valid=1 with out_ready=0 SHALL never lose or alter the held result.

Reset
REQ-023 While reset=1, the FSM SHALL be in IDLE and all outputs SHALL be: out_valid 0, result 0, zero 0, illegal 0, busy 0, in_ready 0.
REQ-024 Reset asserted in EXEC or DONE SHALL abandon the operation; no out_valid SHALL follow.
REQ-025 in_ready SHALL rise on the first clock edge after reset deasserts.

Configuration
REQ-026 Macro ALU_MULDIV_EN.
  - Defined: R-type funct7 0x01 decodes MUL (000), MULHU (011), DIV (100), DIVU (101), REM (110), REMU (111), each iterative with EXEC lasting exactly WIDTH cycles (out_valid at acceptance+WIDTH+1). funct3 001/010 with funct7 0x01 SHALL set illegal.
  - Undefined: every funct7 0x01 request SHALL set illegal=1 with single-cycle timing, and no muldiv logic is synthesised.
REQ-027 Divide by zero: quotient all-ones, remainder = op_a. Signed overflow (MIN / -1): quotient MIN, remainder 0.

Structure
REQ-028 Shared package alu_pkg SHALL hold the operation-code constants, alu_op class codes, FSM state encoding and funct7 constants 0x00, 0x20 and 0x01.
REQ-029 Iterative multiply/divide SHALL live in sub-module alu_muldiv_iter (start/done interface), instantiated only under ALU_MULDIV_EN.

Verification
REQ-030 R-type funct7=0x20, funct3=000, a=5, b=7, out_ready=1 -> out_valid one cycle later, result=0xFFFFFFFE, zero=0.
REQ-031 I-type funct3=101, funct7=0x20, a=0x80000000, b=4 -> result=0xF8000000; same request with funct7=0x00 -> 0x08000000.
REQ-032 out_ready held 0 for 5 cycles after an ADD of 3+4 -> result stays 7 and out_valid stays 1. Then out_ready=1 together with a new in_valid (SLT of -1 vs 1) -> next cycle result=1, with no bubble.
REQ-033 ALU_MULDIV_EN defined, DIVU a=100, b=0 -> out_valid at cycle 33, result=0xFFFFFFFF, in_ready=0 throughout EXEC; REM a=0x80000000, b=0xFFFFFFFF -> result 0.
REQ-034 Reset asserted at EXEC cycle 10 of a MUL -> all outputs 0 immediately, no out_valid afterwards, in_ready=1 on the first edge after release.
REQ-035 Without ALU_MULDIV_EN, funct7=0x01, funct3=000 -> illegal=1 and result=0 one cycle after acceptance.
